// File: rtl/system_bus_memory_target.sv
// ---------------------------------------------------------------------------
// system_bus_memory_target
//
// Responder end of the system bus. It holds DEPTH = 2**ADDR_WIDTH words of
// 32 bits. It serves word-addressed reads and byte-enabled writes. After
// reset a sequencer clears every word to zero, one word per cycle. The target
// then accepts one request per cycle with no wait states. Read data returns
// READ_LATENCY cycles after acceptance, marked by a one-cycle valid strobe.
//
// Ports:
//   clk                         system clock, rising-edge active
//   reset                       asynchronous, active-high reset
//   system_bus_ready            high when a request can be accepted this cycle
//   system_bus_addr[31:0]       byte address; bits [ADDR_WIDTH+1:2] pick the word
//   system_bus_byte_enable[3:0] write lane enables; bit i covers bits [8i+7:8i]
//   system_bus_read_req         read request, qualified by ready
//   system_bus_write_req        write request, qualified by ready
//   system_bus_write_data[31:0] write data
//   system_bus_read_data[31:0]  read response data; holds last response when idle
//   system_bus_read_data_valid  one-cycle strobe marking valid read data
//
// Parameters:
//   ADDR_WIDTH    word-address bits (1..29)
//   READ_LATENCY  cycles from read acceptance to the valid strobe (1..4)
// ---------------------------------------------------------------------------
module system_bus_memory_target #(
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   output logic        system_bus_ready,
   input  logic [31:0] system_bus_addr,
   input  logic [3:0]  system_bus_byte_enable,
   input  logic        system_bus_read_req,
   input  logic        system_bus_write_req,
   input  logic [31:0] system_bus_write_data,
   output logic [31:0] system_bus_read_data,
   output logic        system_bus_read_data_valid
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {
      ST_INIT,
      ST_READY
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] clear_count;
   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] word_addr;
   logic                  accept_read;
   logic                  accept_write;
   logic                  clear_done;
   logic                  unused_addr_bits;

   logic                  pipe_valid [READ_LATENCY];
   logic [31:0]           pipe_data  [READ_LATENCY];

   // Only the word-select bits of the byte address matter. Higher bits make
   // the memory alias modulo DEPTH, and the byte offset is ignored.
   assign word_addr        = system_bus_addr[ADDR_WIDTH+1:2];
   assign unused_addr_bits = ^{system_bus_addr[31:ADDR_WIDTH+2], system_bus_addr[1:0]};

   assign clear_done   = (clear_count == ADDR_WIDTH'(DEPTH - 1));
   assign accept_read  = system_bus_ready && system_bus_read_req;
   assign accept_write = system_bus_ready && system_bus_write_req;

   // State register and clear counter. Reset returns to INIT at once, so
   // ready drops combinationally with the reset assertion. The counter
   // restarts from word 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_INIT;
         clear_count <= '0;
      end else begin
         state <= state_next;
         if (state == ST_INIT) begin
            clear_count <= clear_count + 1'b1;
         end
      end
   end

   // Next-state and ready decode. INIT hands over to READY once the last word
   // has been cleared. READY is left only through reset.
   always_comb begin
      state_next       = state;
      system_bus_ready = 1'b0;
      case (state)
         ST_INIT: begin
            if (clear_done) begin
               state_next = ST_READY;
            end
         end
         ST_READY: begin
            system_bus_ready = 1'b1;
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

   // Memory array. During INIT the sequencer zeroes one word per cycle.
   // Bus writes are possible only once ready, so the two never collide.
   // There is no reset on the array itself; clearing it is the INIT
   // sequencer's job.
   always_ff @(posedge clk) begin
      if (state == ST_INIT) begin
         mem[clear_count] <= '0;
      end else if (accept_write) begin
         for (int i = 0; i < 4; i++) begin
            if (system_bus_byte_enable[i]) begin
               mem[word_addr][8*i +: 8] <= system_bus_write_data[8*i +: 8];
            end
         end
      end
   end

   // Read latency pipeline. Stage 0 samples the word at the acceptance edge.
   // Non-blocking semantics mean a same-cycle write is not yet visible, which
   // gives read-before-write. A data register loads only when valid data
   // arrives, so the final stage holds the last response between strobes.
   // Reset discards any reads still in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < READ_LATENCY; s++) begin
            pipe_valid[s] <= 1'b0;
            pipe_data[s]  <= '0;
         end
      end else begin
         pipe_valid[0] <= accept_read;
         if (accept_read) begin
            pipe_data[0] <= mem[word_addr];
         end
         for (int s = 1; s < READ_LATENCY; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            if (pipe_valid[s-1]) begin
               pipe_data[s] <= pipe_data[s-1];
            end
         end
      end
   end

   assign system_bus_read_data_valid = pipe_valid[READ_LATENCY-1];
   assign system_bus_read_data       = pipe_data[READ_LATENCY-1];

endmodule

// File: doc/system_bus_memory_target.md
Name: system_bus_memory_target

Overview:
Responder end of the system bus. It serves word-addressed reads and byte-enabled writes from initiators such as the CPU instruction fetch and data units, using an internal memory of DEPTH 32-bit words. After reset it clears the memory to zero using a sequencer, then accepts requests. Read data returns after a fixed, parameterised latency with a valid strobe.

Parameters:
ADDR_WIDTH, 10, word-address bits; DEPTH = 2**ADDR_WIDTH words.
READ_LATENCY, 1, cycles from read acceptance to read_data_valid; legal range 1..4.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
system_bus_ready  output  1  high when the target can accept a request this cycle.
system_bus_addr  input  32  byte address; bits [ADDR_WIDTH+1:2] select the word; other bits are ignored.
system_bus_byte_enable  input  4  write lane enables; bit i covers data bits [8i+7:8i].
system_bus_read_req  input  1  read request; qualified by ready.
system_bus_write_req  input  1  write request; qualified by ready.
system_bus_write_data  input  32  write data.
system_bus_read_data  output  32  read response data.
system_bus_read_data_valid  output  1  one-cycle strobe marking valid read_data.

Behaviour:
- Reset values:
  - state=INIT, clear counter=0.
  - system_bus_ready=0, system_bus_read_data=0, system_bus_read_data_valid=0.
  - Latency pipeline valid bits=0.
  - Reset is asynchronous: outputs take these values immediately on assertion, not at the next edge.
- States: INIT, READY.
- INIT:
  - Each cycle writes 0 to word[counter], then increments counter.
  - When counter==DEPTH-1 is written, the next state is READY.
  - INIT lasts exactly DEPTH cycles after reset deassertion.
  - ready=0 throughout; requests are ignored (not queued) and produce no response.
- READY:
  - ready=1 every cycle; there are no wait states.
  - The state never leaves READY except via reset.
- Acceptance: a request is accepted on a rising edge where ready=1 and the request bit is 1.
- Write, when accepted:
  - word[addr] lanes with byte_enable[i]=1 take the corresponding write_data bytes at that edge.
  - byte_enable=0000 is accepted and changes nothing.
- Read, when accepted:
  - read_data_valid=1 exactly READ_LATENCY cycles after the acceptance edge.
  - read_data holds word[addr] as sampled at acceptance (read-before-write semantics).
  - byte_enable is ignored for reads; the full word is always returned.
- Pipelining:
  - One read per cycle sustained; back-to-back reads yield back-to-back valid strobes, in order.
  - Pipeline depth is READ_LATENCY stages of {valid, data}.
- Simultaneous read_req and write_req on the same address:
  - The read returns the old word.
  - The write is applied.
  - Exactly one read response is produced.
- read_data when valid=0: holds the last returned value (0 after reset). Verification must not check it.
- Address aliasing: addresses beyond DEPTH words wrap modulo DEPTH; addr[1:0] is ignored.
- Reset mid-operation:
  - In-flight reads are discarded; no valid strobe is emitted for them.
  - Memory clearing restarts from word 0.
  - Partially completed INIT is restarted.
- Requests while ready=0 have no side effects on memory or the response pipeline.

Test Plan:
- Reset, then idle (ADDR_WIDTH=4): ready stays 0 for exactly 16 cycles after deassertion, then 1. A read of 0x0000_003C returns 0x0000_0000 after READ_LATENCY cycles.
- Write 0xDEADBEEF to 0x10 with byte_enable=1111, then write 0x000000AA with byte_enable=0001 to the same address; read 0x10 -> 0xDEADBEAA. Repeat for READ_LATENCY=1 and 3; valid occurs 1 and 3 cycles after acceptance respectively.
- Reads to 0x0, 0x4, 0x8 on consecutive cycles (data 1, 2, 3 preloaded): valid high for 3 consecutive cycles, data 1, 2, 3 in order.
- Same-cycle read+write of 0x55 to 0x20, previously holding 0x11: the response is 0x11. A subsequent read returns 0x55.
- Requests issued during INIT (write 0xFFFFFFFF to 0x0): no valid strobe appears; after INIT, a read of 0x0 returns 0.
- Assert reset with 2 reads in flight (READ_LATENCY=4): valid never asserts for them, ready drops immediately, and the INIT clear restarts. A write of 0x1234 to 0x8 made before reset reads back 0 after INIT completes.
